// File: rtl/pin_mon_pkg.sv
// rtl/pin_mon_pkg.sv - shared state type and width helpers for the pin activity monitor
package pin_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Channel index is at least one bit wide so a single-pin build still has a port.
  function automatic int ch_width(input int n_ch);
    return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
  endfunction

  function automatic int pw_width(input int min_pulse);
    return clog2(min_pulse + 1);
  endfunction

endpackage

// File: rtl/pin_edge_counter.sv
// rtl/pin_edge_counter.sv - per-pin edge counters with saturation and short-pulse detection
module pin_edge_counter
  import pin_mon_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MIN_PULSE = 2
) (
  input  logic             pj_clk,
  input  logic             pj_reset,
  input  logic             clr,
  input  logic             en,
  input  logic             pin,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] rise_nxt,
  output logic [CNT_W-1:0] fall_nxt,
  output logic             short_nxt
);

  localparam int PW_W = pw_width(MIN_PULSE);
  localparam logic [PW_W-1:0] RUN_MAX = PW_W'(MIN_PULSE);

  logic            prev;
  logic            seen;
  logic            seen_nxt;
  logic            short_flag;
  logic [PW_W-1:0] run;
  logic [PW_W-1:0] run_nxt;
  logic            rise;
  logic            fall;
  logic            pin_edge;
  logic            too_short;

  assign rise      = pin & ~prev;
  assign fall      = ~pin & prev;
  assign pin_edge  = rise | fall;
  // run counts cycles since the last edge, so run+1 is the length of the level just ended.
  assign too_short = (int'(run) + 1) < MIN_PULSE;

  always_comb begin
    rise_nxt  = rise_cnt;
    fall_nxt  = fall_cnt;
    run_nxt   = run;
    seen_nxt  = seen;
    short_nxt = short_flag;
    if (clr) begin
      rise_nxt  = '0;
      fall_nxt  = '0;
      run_nxt   = '0;
      seen_nxt  = 1'b0;
      short_nxt = 1'b0;
    end else if (en) begin
      if (rise && (rise_cnt != '1)) rise_nxt = rise_cnt + CNT_W'(1);
      if (fall && (fall_cnt != '1)) fall_nxt = fall_cnt + CNT_W'(1);
      if (pin_edge) begin
        run_nxt  = '0;
        seen_nxt = 1'b1;
        if (seen && too_short) short_nxt = 1'b1;
      end else if (run != RUN_MAX) begin
        run_nxt = run + PW_W'(1);
      end
    end
  end

  always_ff @(posedge pj_clk) begin
    if (pj_reset) begin
      prev       <= 1'b0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      run        <= '0;
      seen       <= 1'b0;
      short_flag <= 1'b0;
    end else begin
      prev       <= pin;
      rise_cnt   <= rise_nxt;
      fall_cnt   <= fall_nxt;
      run        <= run_nxt;
      seen       <= seen_nxt;
      short_flag <= short_nxt;
    end
  end

endmodule

// File: rtl/pin_activity_monitor.sv
// rtl/pin_activity_monitor.sv - multi-pin edge/pulse monitor with frozen valid/ready statistics dump
module pin_activity_monitor
  import pin_mon_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int CNT_W     = 16,
  parameter int MIN_PULSE = 2,
  localparam int CH_W     = ch_width(N_CH)
) (
  input  logic              pj_clk,
  input  logic              pj_reset,
  input  logic              arm,
  input  logic [N_CH-1:0]   pin_in,
  input  logic              snap_req,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CH_W-1:0]   rd_chan,
  output logic [CNT_W-1:0]  rd_rise,
  output logic [CNT_W-1:0]  rd_fall,
  output logic              rd_short,
  output logic [2*N_CH-1:0] cov,
  output logic              busy,
  output logic              done
);

  mon_state_t state;
  mon_state_t state_nxt;

  logic [CNT_W-1:0] rise_cnt [N_CH];
  logic [CNT_W-1:0] fall_cnt [N_CH];
  logic [CNT_W-1:0] rise_nxt [N_CH];
  logic [CNT_W-1:0] fall_nxt [N_CH];
  logic [N_CH-1:0]  short_nxt;
  logic             clr;
  logic             en;
  logic             snap_take;
  logic             beat_take;
  logic             last_beat;
  logic [CH_W-1:0]  chan_nxt;

  assign clr       = (state == ST_IDLE) && arm;
  assign en        = (state == ST_ARMED);
  assign snap_take = (state == ST_ARMED) && snap_req;
  assign beat_take = (state == ST_DUMP) && rd_ready;
  assign last_beat = (rd_chan == CH_W'(N_CH - 1));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pin_edge_counter #(
      .CNT_W     (CNT_W),
      .MIN_PULSE (MIN_PULSE)
    ) u_cnt (
      .pj_clk    (pj_clk),
      .pj_reset  (pj_reset),
      .clr       (clr),
      .en        (en),
      .pin       (pin_in[i]),
      .rise_cnt  (rise_cnt[i]),
      .fall_cnt  (fall_cnt[i]),
      .rise_nxt  (rise_nxt[i]),
      .fall_nxt  (fall_nxt[i]),
      .short_nxt (short_nxt[i])
    );
  end

  always_ff @(posedge pj_clk) begin
    if (pj_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    chan_nxt  = rd_chan;
    case (state)
      ST_IDLE:  if (arm) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (snap_req) begin
          state_nxt = ST_DUMP;
          chan_nxt  = '0;
        end else if (!arm) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DUMP: begin
        if (beat_take) begin
          if (last_beat) begin
            state_nxt = ST_DONE;
            chan_nxt  = '0;
          end else begin
            chan_nxt  = rd_chan + CH_W'(1);
          end
        end
      end
      ST_DONE:  if (!arm) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Beat data is loaded from the counters' next values so an edge in the snap cycle is included.
  always_ff @(posedge pj_clk) begin
    if (pj_reset) begin
      rd_chan  <= '0;
      rd_rise  <= '0;
      rd_fall  <= '0;
      rd_short <= 1'b0;
    end else begin
      rd_chan <= chan_nxt;
      if (state_nxt == ST_DUMP) begin
        rd_rise  <= rise_nxt[chan_nxt];
        rd_fall  <= fall_nxt[chan_nxt];
        rd_short <= short_nxt[chan_nxt];
      end else begin
        rd_rise  <= '0;
        rd_fall  <= '0;
        rd_short <= 1'b0;
      end
    end
  end

  always_ff @(posedge pj_clk) begin
    if (pj_reset) begin
      cov <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cov[2*i]   <= |rise_cnt[i];
        cov[2*i+1] <= |fall_cnt[i];
      end
    end
  end

  assign rd_valid = (state == ST_DUMP);
  assign busy     = (state == ST_ARMED) || (state == ST_DUMP);
  assign done     = (state == ST_DONE);

  // snap_take is kept as a named term for readability of the ARMED exit condition.
  logic unused_snap_take;
  assign unused_snap_take = snap_take;

endmodule
